// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiply/divide FSM encoding, iteration count,
// HI/LO write-data select codes and the two's-complement negation helper.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    localparam int MD_ITER  = 32;
    localparam int MD_CNT_W = $clog2(MD_ITER);
    localparam logic [MD_CNT_W-1:0] MD_LAST = MD_CNT_W'(MD_ITER - 1);

    localparam int HILO_SEL_W = 2;

    typedef enum logic [HILO_SEL_W-1:0] {
        WD_SEL_ALU = 2'd0,
        WD_SEL_MEM = 2'd1,
        WD_SEL_HI  = 2'd2,
        WD_SEL_LO  = 2'd3
    } wd_sel_t;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration on the {acc_hi, lo, q_m1} accumulator:
// add/subtract the multiplicand into the upper half, then arithmetic shift right.
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] lo,
    input  logic             q_m1,
    input  logic [WIDTH-1:0] multiplicand,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo,
    output logic             nxt_q_m1
);

    logic [WIDTH:0] hi_ext_s;
    logic [WIDTH:0] m_ext_s;
    logic [WIDTH:0] sum_s;

    // One guard bit keeps the add exact for the most negative multiplicand.
    assign hi_ext_s = {acc_hi[WIDTH-1], acc_hi};
    assign m_ext_s  = {multiplicand[WIDTH-1], multiplicand};

    // Booth recoding of {lo[0], q_m1}
    always_comb begin
        sum_s = hi_ext_s;
        case ({lo[0], q_m1})
            2'b01:   sum_s = hi_ext_s + m_ext_s;
            2'b10:   sum_s = hi_ext_s - m_ext_s;
            default: sum_s = hi_ext_s;
        endcase
    end

    assign nxt_hi   = sum_s[WIDTH:1];
    assign nxt_lo   = {sum_s[0], lo[WIDTH-1:1]};
    assign nxt_q_m1 = lo[0];

endmodule

// File: rtl/mult_div.sv
// Sequential signed multiply (Booth) / divide (restoring) unit producing HI/LO
// for the multicycle datapath; 32 iterations per operation.
module mult_div
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             start_mult,
    input  logic             start_div,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    md_state_t state_r, state_nxt_s;

    logic [WIDTH-1:0]    acc_hi_r, acc_lo_r, opnd_r, hi_r, lo_r;
    logic                q_m1_r, neg_q_r, neg_r_r, busy_r, done_r, div_zero_r;
    logic [MD_CNT_W-1:0] count_r;

    logic             last_step_s, div_by_zero_s;
    logic [WIDTH-1:0] booth_hi_s, booth_lo_s;
    logic             booth_q_s;
    logic [WIDTH:0]   div_shift_s, div_diff_s;
    logic [WIDTH-1:0] div_rem_s, div_quo_s;
    logic [WIDTH-1:0] neg0_in_s, neg1_in_s, neg0_out_s, neg1_out_s;

    assign last_step_s   = (count_r == MD_LAST);
    assign div_by_zero_s = (b_in == {WIDTH{1'b0}});

    booth_step #(.WIDTH(WIDTH)) u_booth_step (
        .acc_hi       (acc_hi_r),
        .lo           (acc_lo_r),
        .q_m1         (q_m1_r),
        .multiplicand (opnd_r),
        .nxt_hi       (booth_hi_s),
        .nxt_lo       (booth_lo_s),
        .nxt_q_m1     (booth_q_s)
    );

    // Restoring divide step: partial remainder in acc_hi_r, dividend/quotient in acc_lo_r
    always_comb begin
        div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        if (div_diff_s[WIDTH]) begin
            div_rem_s = div_shift_s[WIDTH-1:0];
            div_quo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
        end else begin
            div_rem_s = div_diff_s[WIDTH-1:0];
            div_quo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
        end
    end

    // Negators take operand magnitudes at start and apply result signs at the end
    always_comb begin
        if (state_r == ST_IDLE) begin
            neg0_in_s = a_in;
            neg1_in_s = b_in;
        end else begin
            neg0_in_s = div_quo_s;
            neg1_in_s = div_rem_s;
        end
    end

    assign neg0_out_s = neg32(neg0_in_s);
    assign neg1_out_s = neg32(neg1_in_s);

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; start_mult has priority over start_div
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_mult) begin
                    state_nxt_s = ST_MULT;
                end else if (start_div) begin
                    state_nxt_s = div_by_zero_s ? ST_DONE : ST_DIV;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MULT: begin
                if (last_step_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_MULT;
                end
            end
            ST_DIV: begin
                if (last_step_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DIV;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath, HI/LO result registers and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_hi_r   <= {WIDTH{1'b0}};
            acc_lo_r   <= {WIDTH{1'b0}};
            opnd_r     <= {WIDTH{1'b0}};
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            q_m1_r     <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            count_r    <= {MD_CNT_W{1'b0}};
        end else begin
            busy_r     <= (state_nxt_s == ST_MULT) || (state_nxt_s == ST_DIV);
            done_r     <= (state_nxt_s == ST_DONE);
            div_zero_r <= (state_r == ST_IDLE) && !start_mult && start_div && div_by_zero_s;
            case (state_r)
                ST_IDLE: begin
                    count_r <= {MD_CNT_W{1'b0}};
                    if (start_mult) begin
                        acc_hi_r <= {WIDTH{1'b0}};
                        acc_lo_r <= b_in;
                        q_m1_r   <= 1'b0;
                        opnd_r   <= a_in;
                    end else if (start_div) begin
                        acc_hi_r <= {WIDTH{1'b0}};
                        acc_lo_r <= a_in[WIDTH-1] ? neg0_out_s : a_in;
                        opnd_r   <= b_in[WIDTH-1] ? neg1_out_s : b_in;
                        neg_q_r  <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                        neg_r_r  <= a_in[WIDTH-1];
                    end
                end
                ST_MULT: begin
                    acc_hi_r <= booth_hi_s;
                    acc_lo_r <= booth_lo_s;
                    q_m1_r   <= booth_q_s;
                    count_r  <= count_r + MD_CNT_W'(1);
                    if (last_step_s) begin
                        hi_r <= booth_hi_s;
                        lo_r <= booth_lo_s;
                    end
                end
                ST_DIV: begin
                    acc_hi_r <= div_rem_s;
                    acc_lo_r <= div_quo_s;
                    count_r  <= count_r + MD_CNT_W'(1);
                    if (last_step_s) begin
                        lo_r <= neg_q_r ? neg0_out_s : div_quo_s;
                        hi_r <= neg_r_r ? neg1_out_s : div_rem_s;
                    end
                end
                default: count_r <= {MD_CNT_W{1'b0}};
            endcase
        end
    end

    assign hi_out   = hi_r;
    assign lo_out   = lo_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;

endmodule

// File: tb/tb_mult_div.sv
// Scoreboard bench for mult_div: stimulus pushes reference results computed
// with 64-bit signed arithmetic; a monitor pops and compares on every done.
module tb_mult_div;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a_in, b_in;
    logic        start_mult, start_div;
    logic [31:0] hi_out, lo_out;
    logic        busy, done, div_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          due;
        int          busy_cycles;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          busy_cnt = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    mult_div #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .a_in       (a_in),
        .b_in       (b_in),
        .start_mult (start_mult),
        .start_div  (start_div),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every completion against the oldest expected result
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (div_zero && !done) begin
                checks++;
                failures++;
                $display("FAIL div_zero_without_done at cycle %0d", cyc);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done hi=%h lo=%h at cycle %0d", hi_out, lo_out, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("hi", {32'd0, hi_out}, {32'd0, e.hi});
                    chk("lo", {32'd0, lo_out}, {32'd0, e.lo});
                    chk("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
                    chk("latency_cycle", 64'(cyc), 64'(e.due));
                    chk("busy_cycles", 64'(busy_cnt), 64'(e.busy_cycles));
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic issue(input bit is_mult, input logic [31:0] a, input logic [31:0] b, input bit both);
        exp_t        e;
        logic [63:0] p;
        longint      sa, sbv;
        @(negedge clk);
        a_in       = a;
        b_in       = b;
        start_mult = is_mult || both;
        start_div  = !is_mult || both;
        sa  = $signed(a);
        sbv = $signed(b);
        if (is_mult || both) begin
            p = sa * sbv;
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.dz = 1'b0;
            e.busy_cycles = 32;
            e.due = cyc + 33;
        end else if (b == 32'd0) begin
            e.hi = model_hi;
            e.lo = model_lo;
            e.dz = 1'b1;
            e.busy_cycles = 0;
            e.due = cyc + 1;
        end else begin
            p = sa / sbv;
            e.lo = p[31:0];
            p = sa % sbv;
            e.hi = p[31:0];
            e.dz = 1'b0;
            e.busy_cycles = 32;
            e.due = cyc + 33;
        end
        model_hi = e.hi;
        model_lo = e.lo;
        sb.push_back(e);
        @(negedge clk);
        start_mult = 1'b0;
        start_div  = 1'b0;
        a_in       = $urandom;
        b_in       = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout pending=%0d at cycle %0d", sb.size(), cyc);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        int          n;
        reset      = 1'b1;
        a_in       = 32'd0;
        b_in       = 32'd0;
        start_mult = 1'b0;
        start_div  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_hi", {32'd0, hi_out}, 64'd0);
        chk("reset_lo", {32'd0, lo_out}, 64'd0);
        chk("reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
        reset = 1'b0;

        issue(1'b1, 32'd7, 32'hFFFF_FFFD, 1'b0);        wait_idle();
        issue(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0); wait_idle();
        issue(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);         wait_idle();
        issue(1'b0, 32'd100, 32'd7, 1'b0);               wait_idle();
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); wait_idle();
        issue(1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0); wait_idle();
        issue(1'b0, 32'hCAFE_0001, 32'd0, 1'b0);         wait_idle();
        chk("hold_hi_after_dz", {32'd0, hi_out}, {32'd0, model_hi});
        issue(1'b1, 32'hFFFF_FFFB, 32'd9, 1'b1);         wait_idle();

        // Divide request during a multiply must be dropped
        issue(1'b1, 32'h0001_0003, 32'hFFF0_0007, 1'b0);
        repeat (8) @(negedge clk);
        start_div = 1'b1;
        b_in      = 32'd0;
        @(negedge clk);
        start_div = 1'b0;
        wait_idle();

        // Start held in the DONE cycle is ignored
        issue(1'b1, 32'd3, 32'd5, 1'b0);
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        start_mult = 1'b1;
        @(negedge clk);
        start_mult = 1'b0;
        @(negedge clk);
        chk("restart_in_done_ignored", {63'd0, busy}, 64'd0);
        wait_idle();

        // Reset in the middle of a divide aborts without done
        issue(1'b0, 32'hFFFF_0000, 32'd13, 1'b0);
        repeat (13) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_hi", {32'd0, hi_out}, 64'd0);
        chk("abort_lo", {32'd0, lo_out}, 64'd0);
        chk("abort_flags", {61'd0, busy, done, div_zero}, 64'd0);
        sb.delete();
        model_hi = 32'd0;
        model_lo = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        issue(1'b1, 32'hFFFF_FF00, 32'h0000_0101, 1'b0); wait_idle();

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 28);
            issue(($urandom_range(0, 1) == 1), ra, rb, 1'b0);
            wait_idle();
        end

        repeat (5) @(negedge clk);
        chk("final_hold_hi", {32'd0, hi_out}, {32'd0, model_hi});
        chk("final_hold_lo", {32'd0, lo_out}, {32'd0, model_lo});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
